pe_feeder: RTL and testbench

Sequencing front-end for `parallel_pe`. It reads 512-bit neuron and weight vectors from two single-port buffers and streams them into the PE with correct `ctl` framing: clear on the first beat, finish on the last. It then captures the PE's 32-bit dot-product result and hands it downstream over a valid/ready port. One start command computes `num_out` outputs of `vec_len` beats each. The neuron vector is reused for every output; weights are consumed contiguously.

---
 rtl/pe_feeder_pkg.sv | 23 ++
 rtl/pe_feeder_addr_gen.sv | 69 ++++++
 rtl/pe_feeder.sv | 169 ++++++++++++++++
 tb/tb_pe_feeder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the pe_feeder sequencing front-end.
package pe_feeder_pkg;

  localparam int unsigned PE_DATA_W = 512;
  localparam int unsigned PE_PSUM_W = 32;

  // Bit positions within pe_ctl.
  localparam int unsigned CTL_FIRST = 0;
  localparam int unsigned CTL_LAST  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StOut
  } state_e;

  // Clamp negative (two's complement) partial sums to zero.
  function automatic logic [PE_PSUM_W-1:0] relu(input logic [PE_PSUM_W-1:0] x);
    return x[PE_PSUM_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/pe_feeder_addr_gen.sv
// Beat, output-index and address counters for pe_feeder. Latches the command
// configuration on load and produces first/last beat and last-output flags.
module pe_feeder_addr_gen
  import pe_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned NUM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [NUM_W-1:0]  num_out,
  input  logic [ADDR_W-1:0] nrn_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic              beat_adv,
  input  logic              out_adv,
  output logic [ADDR_W-1:0] nrn_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [NUM_W-1:0]  idx,
  output logic              first,
  output logic              last,
  output logic              last_out
);

  logic [LEN_W-1:0]  len_q;
  logic [NUM_W-1:0]  num_q;
  logic [ADDR_W-1:0] nrn_base_q;
  logic [LEN_W-1:0]  beat_q;
  logic [NUM_W-1:0]  idx_q;
  logic [ADDR_W-1:0] wgt_ptr_q;

  // Neuron address restarts per output; weight pointer runs across outputs.
  assign nrn_addr = nrn_base_q + ADDR_W'(beat_q);
  assign wgt_addr = wgt_ptr_q;
  assign idx      = idx_q;
  assign first    = (beat_q == '0);
  assign last     = (beat_q == len_q - LEN_W'(1));
  assign last_out = (idx_q == num_q - NUM_W'(1));

  // Counter state: load on command accept, advance per issued beat / handed-off output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      num_q      <= '0;
      nrn_base_q <= '0;
      beat_q     <= '0;
      idx_q      <= '0;
      wgt_ptr_q  <= '0;
    end else if (load) begin
      len_q      <= vec_len;
      num_q      <= num_out;
      nrn_base_q <= nrn_base;
      beat_q     <= '0;
      idx_q      <= '0;
      wgt_ptr_q  <= wgt_base;
    end else begin
      if (beat_adv) begin
        beat_q    <= last ? '0 : beat_q + LEN_W'(1);
        wgt_ptr_q <= wgt_ptr_q + ADDR_W'(1);
      end
      if (out_adv) begin
        idx_q <= idx_q + NUM_W'(1);
      end
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Sequencing front-end for parallel_pe: reads neuron/weight vectors from two
// single-port buffers, frames them for the PE, captures each dot-product result
// and hands it downstream over valid/ready.
// Optional feature: define PE_FEEDER_RELU_EN to apply ReLU to captured results.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned NUM_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     cfg_vec_len_i,
  input  logic [NUM_W-1:0]     cfg_num_out_i,
  input  logic [ADDR_W-1:0]    cfg_nrn_base_i,
  input  logic [ADDR_W-1:0]    cfg_wgt_base_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 nrn_rd_en_o,
  output logic [ADDR_W-1:0]    nrn_rd_addr_o,
  input  logic [PE_DATA_W-1:0] nrn_rd_data_i,
  output logic                 wgt_rd_en_o,
  output logic [ADDR_W-1:0]    wgt_rd_addr_o,
  input  logic [PE_DATA_W-1:0] wgt_rd_data_i,
  output logic [PE_DATA_W-1:0] pe_neuron_o,
  output logic [PE_DATA_W-1:0] pe_weight_o,
  output logic [1:0]           pe_ctl_o,
  output logic                 pe_vld_o,
  input  logic [PE_PSUM_W-1:0] pe_result_i,
  input  logic                 pe_vld_i,
  output logic                 res_vld_o,
  input  logic                 res_rdy_i,
  output logic [PE_PSUM_W-1:0] res_data_o,
  output logic [NUM_W-1:0]     res_idx_o
);

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 res_vld_q;
  logic [PE_PSUM_W-1:0] res_data_q;
  logic                 pe_vld_q;
  logic [1:0]           pe_ctl_q;

  logic                 load;
  logic                 rd_en;
  logic                 out_adv;
  logic                 first;
  logic                 last;
  logic                 last_out;
  logic                 cfg_zero;
  logic [ADDR_W-1:0]    nrn_addr;
  logic [ADDR_W-1:0]    wgt_addr;
  logic [NUM_W-1:0]     idx;
  logic [PE_PSUM_W-1:0] res_capture;

  assign cfg_zero = (cfg_vec_len_i == '0) || (cfg_num_out_i == '0);
  assign load     = (state_q == StIdle) && start_i;
  assign rd_en    = (state_q == StIssue);
  assign out_adv  = (state_q == StOut) && res_rdy_i && !last_out;

`ifdef PE_FEEDER_RELU_EN
  assign res_capture = relu(pe_result_i);
`else
  assign res_capture = pe_result_i;
`endif

  pe_feeder_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .NUM_W  (NUM_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .vec_len  (cfg_vec_len_i),
    .num_out  (cfg_num_out_i),
    .nrn_base (cfg_nrn_base_i),
    .wgt_base (cfg_wgt_base_i),
    .beat_adv (rd_en),
    .out_adv  (out_adv),
    .nrn_addr (nrn_addr),
    .wgt_addr (wgt_addr),
    .idx      (idx),
    .first    (first),
    .last     (last),
    .last_out (last_out)
  );

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign nrn_rd_en_o   = rd_en;
  assign wgt_rd_en_o   = rd_en;
  assign nrn_rd_addr_o = nrn_addr;
  assign wgt_rd_addr_o = wgt_addr;
  assign pe_vld_o      = pe_vld_q;
  assign pe_ctl_o      = pe_ctl_q;
  // Buffer data is gated so the PE bus idles at zero between beats and in reset.
  assign pe_neuron_o   = pe_vld_q ? nrn_rd_data_i : '0;
  assign pe_weight_o   = pe_vld_q ? wgt_rd_data_i : '0;
  assign res_vld_o     = res_vld_q;
  assign res_data_o    = res_data_q;
  assign res_idx_o     = idx;

  // Control FSM with registered busy/done/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (cfg_zero) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StIssue;
              busy_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (last) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (pe_vld_i) begin
            res_data_q <= res_capture;
            res_vld_q  <= 1'b1;
            state_q    <= StOut;
          end
        end
        StOut: begin
          if (res_rdy_i) begin
            res_vld_q <= 1'b0;
            if (last_out) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Beat framing delayed one cycle to line up with the buffers' read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_vld_q <= 1'b0;
      pe_ctl_q <= 2'b00;
    end else begin
      pe_vld_q            <= rd_en;
      pe_ctl_q[CTL_FIRST] <= rd_en & first;
      pe_ctl_q[CTL_LAST]  <= rd_en & last;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed testbench for pe_feeder with buffer and PE behavioural models.
module tb_pe_feeder;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;
  localparam int NUM_W  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic [LEN_W-1:0]   cfg_vec_len_i = '0;
  logic [NUM_W-1:0]   cfg_num_out_i = '0;
  logic [ADDR_W-1:0]  cfg_nrn_base_i = '0;
  logic [ADDR_W-1:0]  cfg_wgt_base_i = '0;
  logic               busy_o, done_o;
  logic               nrn_rd_en_o, wgt_rd_en_o;
  logic [ADDR_W-1:0]  nrn_rd_addr_o, wgt_rd_addr_o;
  logic [511:0]       nrn_rd_data_i = '0;
  logic [511:0]       wgt_rd_data_i = '0;
  logic [511:0]       pe_neuron_o, pe_weight_o;
  logic [1:0]         pe_ctl_o;
  logic               pe_vld_o;
  logic [31:0]        pe_result_i = '0;
  logic               pe_vld_i = 1'b0;
  logic               res_vld_o;
  logic               res_rdy_i = 1'b1;
  logic [31:0]        res_data_o;
  logic [NUM_W-1:0]   res_idx_o;

  always #5 clk = ~clk;

  pe_feeder #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .NUM_W  (NUM_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .cfg_vec_len_i  (cfg_vec_len_i),
    .cfg_num_out_i  (cfg_num_out_i),
    .cfg_nrn_base_i (cfg_nrn_base_i),
    .cfg_wgt_base_i (cfg_wgt_base_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .nrn_rd_en_o    (nrn_rd_en_o),
    .nrn_rd_addr_o  (nrn_rd_addr_o),
    .nrn_rd_data_i  (nrn_rd_data_i),
    .wgt_rd_en_o    (wgt_rd_en_o),
    .wgt_rd_addr_o  (wgt_rd_addr_o),
    .wgt_rd_data_i  (wgt_rd_data_i),
    .pe_neuron_o    (pe_neuron_o),
    .pe_weight_o    (pe_weight_o),
    .pe_ctl_o       (pe_ctl_o),
    .pe_vld_o       (pe_vld_o),
    .pe_result_i    (pe_result_i),
    .pe_vld_i       (pe_vld_i),
    .res_vld_o      (res_vld_o),
    .res_rdy_i      (res_rdy_i),
    .res_data_o     (res_data_o),
    .res_idx_o      (res_idx_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Buffers: neuron word a holds a+1, weight word a holds a+2 (low 32 bits).
  logic [511:0] nrn_mem [256];
  logic [511:0] wgt_mem [256];

  always @(posedge clk) begin
    if (nrn_rd_en_o) nrn_rd_data_i <= nrn_mem[nrn_rd_addr_o];
    if (wgt_rd_en_o) wgt_rd_data_i <= wgt_mem[wgt_rd_addr_o];
  end

  // PE model: low-32-bit multiply-accumulate, result one cycle after last beat.
  logic [31:0] acc = '0;
  logic [31:0] acc_n;
  logic        neg_override = 1'b0;

  always @(posedge clk) begin
    pe_vld_i <= 1'b0;
    if (pe_vld_o) begin
      acc_n = (pe_ctl_o[0] ? 32'd0 : acc) + pe_neuron_o[31:0] * pe_weight_o[31:0];
      acc <= acc_n;
      if (pe_ctl_o[1]) begin
        pe_vld_i    <= 1'b1;
        pe_result_i <= neg_override ? 32'hFFFF_FFF0 : acc_n;
      end
    end
  end

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;
  int t0 = 0;

  // Monitor / ready responder state.
  int          clr_req = 0;
  int          clr_ack = 0;
  int          stall_cfg = 0;
  int          stall_left = 0;
  logic [7:0]  q_nrn[$];
  logic [7:0]  q_wgt[$];
  int          q_rdcyc[$];
  logic [1:0]  q_ctl[$];
  logic [31:0] q_res[$];
  logic [7:0]  q_idx[$];
  int          q_hs[$];
  logic [31:0] q_sdata[$];
  logic [7:0]  q_sidx[$];
  int          first_vld_cyc = -1;
  int          vld_cnt = 0;
  int          rd_in_out = 0;
  int          busy_cnt = 0;

  always @(negedge clk) begin
    int   cyc;
    logic rdy_new;
    if (clr_req != clr_ack) begin
      q_nrn.delete(); q_wgt.delete(); q_rdcyc.delete(); q_ctl.delete();
      q_res.delete(); q_idx.delete(); q_hs.delete(); q_sdata.delete(); q_sidx.delete();
      first_vld_cyc = -1; vld_cnt = 0; rd_in_out = 0; busy_cnt = 0;
      stall_left = stall_cfg;
      clr_ack = clr_req;
    end
    cyc = tick - t0 + 1;
    rdy_new = !(res_vld_o && stall_left > 0);
    if (res_vld_o && stall_left > 0) stall_left--;
    res_rdy_i = rdy_new;
    if (nrn_rd_en_o) begin
      q_nrn.push_back(nrn_rd_addr_o);
      q_rdcyc.push_back(cyc);
    end
    if (wgt_rd_en_o) q_wgt.push_back(wgt_rd_addr_o);
    if (pe_vld_o) q_ctl.push_back(pe_ctl_o);
    if (busy_o) busy_cnt++;
    if (res_vld_o) begin
      vld_cnt++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (nrn_rd_en_o || wgt_rd_en_o) rd_in_out++;
      if (rdy_new) begin
        q_res.push_back(res_data_o);
        q_idx.push_back(res_idx_o);
        q_hs.push_back(cyc);
      end else begin
        q_sdata.push_back(res_data_o);
        q_sidx.push_back(res_idx_o);
      end
    end
  end

  // Issue one command; returns the cycle done_o was seen (-1 on timeout).
  task automatic run_cmd(input int len, input int num, input int nb, input int wb,
                         input int stall, input int restart_at, output int done_cyc);
    stall_cfg = stall;
    clr_req++;
    @(negedge clk);
    cfg_vec_len_i  = LEN_W'(len);
    cfg_num_out_i  = NUM_W'(num);
    cfg_nrn_base_i = ADDR_W'(nb);
    cfg_wgt_base_i = ADDR_W'(wb);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    t0 = tick;
    start_i = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == restart_at) begin
        start_i = 1'b1;
        cfg_vec_len_i = 8'd3;
        cfg_num_out_i = 8'd2;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  initial begin
    int dc;
    int bad;
    int n;
    logic [31:0] exp_neg;

    for (int a = 0; a < 256; a++) begin
      nrn_mem[a] = {480'd0, 32'(a + 1)};
      wgt_mem[a] = {480'd0, 32'(a + 2)};
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd_en", {nrn_rd_en_o, wgt_rd_en_o}, 0);
    check("rst_addr", {nrn_rd_addr_o, wgt_rd_addr_o}, 0);
    check("rst_pe", {pe_vld_o, pe_ctl_o}, 0);
    check("rst_res", {res_vld_o, res_data_o, res_idx_o}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: L=4, N=1, bases 0
    run_cmd(4, 1, 0, 0, 0, 0, dc);
    check("t1_done_cyc", dc, 8);
    check("t1_busy_at_done", busy_o, 0);
    check("t1_ctl_seq", {q_ctl[0], q_ctl[1], q_ctl[2], q_ctl[3]}, 8'b01_00_00_10);
    check("t1_ctl_cnt", q_ctl.size(), 4);
    check("t1_rd_first_cyc", q_rdcyc[0], 1);
    check("t1_rd_last_cyc", q_rdcyc[3], 4);
    check("t1_nrn_addr", {q_nrn[0], q_nrn[1], q_nrn[2], q_nrn[3]}, 32'h0001_0203);
    check("t1_vld_cyc", first_vld_cyc, 7);
    check("t1_result", q_res[0], 40);
    check("t1_idx", q_idx[0], 0);
    @(negedge clk);
    check("t1_done_pulse", done_o, 0);

    // T2: L=1, N=3, wgt_base 0x10
    run_cmd(1, 3, 0, 16, 0, 0, dc);
    check("t2_done_cyc", dc, 13);
    check("t2_ctl", {q_ctl[0], q_ctl[1], q_ctl[2]}, 6'b11_11_11);
    check("t2_wgt_addr", {q_wgt[0], q_wgt[1], q_wgt[2]}, 24'h10_11_12);
    check("t2_nrn_addr", {q_nrn[0], q_nrn[1], q_nrn[2]}, 24'h00_00_00);
    check("t2_nrn_cnt", q_nrn.size(), 3);
    check("t2_idx", {q_idx[0], q_idx[1], q_idx[2]}, 24'h00_01_02);
    for (int k = 0; k < 3; k++) check($sformatf("t2_res%0d", k), q_res[k], 18 + k);

    // T3: L=2, N=2, ready low for 5 cycles on the first result
    run_cmd(2, 2, 32, 48, 5, 0, dc);
    check("t3_vld_cyc", first_vld_cyc, 5);
    check("t3_stall_cnt", q_sdata.size(), 5);
    bad = 0;
    for (int k = 0; k < q_sdata.size(); k++) begin
      if (q_sdata[k] !== 32'd3384 || q_sidx[k] !== 8'd0) bad++;
    end
    check("t3_stable", bad, 0);
    check("t3_rd_in_out", rd_in_out, 0);
    check("t3_hs_cyc", q_hs[0], 10);
    check("t3_next_issue", q_rdcyc[2], 11);
    check("t3_res0", q_res[0], 3384);
    check("t3_res1", q_res[1], 3518);
    check("t3_idx1", q_idx[1], 1);
    check("t3_done_cyc", dc, 16);

    // T4: weight address wrap
    run_cmd(2, 2, 0, 254, 0, 0, dc);
    check("t4_wgt_addr", {q_wgt[0], q_wgt[1], q_wgt[2], q_wgt[3]}, 32'hFEFF_0001);
    check("t4_res0", q_res[0], 770);
    check("t4_res1", q_res[1], 8);

    // T5: num_out = 0
    run_cmd(4, 0, 0, 0, 0, 0, dc);
    check("t5_done_cyc", dc, 1);
    check("t5_no_reads", q_nrn.size(), 0);
    check("t5_no_vld", vld_cnt, 0);
    check("t5_no_busy", busy_cnt, 0);

    // T5b: start while busy is ignored
    run_cmd(2, 1, 0, 0, 0, 2, dc);
    check("t5b_done_cyc", dc, 6);
    check("t5b_reads", q_nrn.size(), 2);
    check("t5b_outs", q_res.size(), 1);
    check("t5b_res", q_res[0], 8);
    repeat (8) @(negedge clk);
    check("t5b_idle_after", busy_o, 0);

    // T6: reset mid-command at cycle 3 of L=8
    clr_req++;
    @(negedge clk);
    cfg_vec_len_i = 8'd8;
    cfg_num_out_i = 8'd1;
    cfg_nrn_base_i = 8'd0;
    cfg_wgt_base_i = 8'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    t0 = tick;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pre_addr", nrn_rd_addr_o, 2);
    #1;
    rst = 1'b1;
    #1;
    check("t6_all_zero", 64'(|{busy_o, done_o, nrn_rd_en_o, nrn_rd_addr_o, wgt_rd_en_o,
          wgt_rd_addr_o, pe_neuron_o, pe_weight_o, pe_ctl_o, pe_vld_o, res_vld_o,
          res_data_o, res_idx_o}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n = q_nrn.size();
    repeat (12) @(negedge clk);
    check("t6_no_resume", q_nrn.size(), n);
    check("t6_idle", busy_o, 0);
    check("t6_no_vld", vld_cnt, 0);

    // T7: negative PE result
    neg_override = 1'b1;
    run_cmd(1, 1, 0, 0, 0, 0, dc);
    neg_override = 1'b0;
`ifdef PE_FEEDER_RELU_EN
    exp_neg = 32'd0;
`else
    exp_neg = 32'hFFFF_FFF0;
`endif
    check("t7_neg_res", q_res[0], exp_neg);
    check("t7_done_cyc", dc, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
